// File: rtl/alarm_sound_controller.sv
// Alarm clock sound controller: rings on a time match, auto-silences, optional snooze.
// Snooze support (SNOOZE state, snooze timer, snooze_count) is built only when ALARM_SNOOZE_EN is defined.
module alarm_sound_controller #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        one_second,
    input  logic        alarm_enable,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        stop_button,
    input  logic        snooze_button,
    output logic        sound_alarm,
    output logic        beep,
    output logic        snoozing,
    output logic [1:0]  snooze_count
);

    localparam int MAX_SECONDS = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int TW          = $clog2(MAX_SECONDS) + 1;
    localparam logic [TW-1:0] RING_LAST = TW'(RING_SECONDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          match;
    logic          stop_prev;
    logic          stop_press;
    logic          snooze_press;
    logic          snooze_allowed;
    logic          snooze_expire;
    logic [TW-1:0] ring_timer;
    logic          ring_entry;
    logic          ring_timeout;
    logic          phase;

    assign match      = alarm_enable && (current_time == alarm_time);
    assign stop_press = stop_button && !stop_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stop_prev <= 1'b0;
        end else begin
            stop_prev <= stop_button;
        end
    end

`ifdef ALARM_SNOOZE_EN
    localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SECONDS - 1);

    logic          snooze_prev;
    logic [TW-1:0] snooze_timer;
    logic          snooze_entry;

    assign snooze_press   = snooze_button && !snooze_prev;
    assign snooze_allowed = (snooze_count < 2'(MAX_SNOOZE));
    assign snooze_entry   = (next_state == SNOOZE) && (state != SNOOZE);
    assign snooze_expire  = (state == SNOOZE) && one_second && (snooze_timer == SNOOZE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snooze_prev <= 1'b0;
        end else begin
            snooze_prev <= snooze_button;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snooze_timer <= '0;
        end else if (snooze_entry) begin
            snooze_timer <= '0;
        end else if ((state == SNOOZE) && one_second) begin
            snooze_timer <= snooze_timer + TW'(1);
        end
    end

    // The count survives DONE so a stopped event keeps its history until the minute passes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snooze_count <= 2'd0;
        end else if (state == IDLE) begin
            snooze_count <= 2'd0;
        end else if ((state == RINGING) && (next_state == SNOOZE)) begin
            snooze_count <= snooze_count + 2'd1;
        end
    end

    assign snoozing = (state == SNOOZE);
`else
    logic snooze_unused;

    assign snooze_unused  = snooze_button ^ (MAX_SNOOZE > 0);
    assign snooze_press   = 1'b0;
    assign snooze_allowed = 1'b0;
    assign snooze_expire  = 1'b0;
    assign snooze_count   = 2'd0;
    assign snoozing       = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Priority inside RINGING/SNOOZE: disable, then stop, then snooze, then timers.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (match) begin
                    next_state = RINGING;
                end
            end
            RINGING: begin
                if (!alarm_enable) begin
                    next_state = IDLE;
                end else if (stop_press) begin
                    next_state = DONE;
                end else if (snooze_press && snooze_allowed) begin
                    next_state = SNOOZE;
                end else if (ring_timeout) begin
                    next_state = DONE;
                end
            end
            SNOOZE: begin
                if (!alarm_enable) begin
                    next_state = IDLE;
                end else if (stop_press) begin
                    next_state = DONE;
                end else if (snooze_expire) begin
                    next_state = RINGING;
                end
            end
            DONE: begin
                if (!match) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ring_entry   = (next_state == RINGING) && (state != RINGING);
    assign ring_timeout = (state == RINGING) && one_second && (ring_timer == RING_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ring_timer <= '0;
        end else if (ring_entry) begin
            ring_timer <= '0;
        end else if ((state == RINGING) && one_second) begin
            ring_timer <= ring_timer + TW'(1);
        end
    end

    // Each ringing episode starts with the beep silent and toggles once per second.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (ring_entry) begin
            phase <= 1'b0;
        end else if ((state == RINGING) && one_second) begin
            phase <= !phase;
        end
    end

    assign sound_alarm = (state == RINGING);
    assign beep        = sound_alarm && phase;

endmodule

// File: tb/tb_alarm_sound_controller.sv
// Directed self-checking bench for alarm_sound_controller with default parameters.
// Snooze scenarios are exercised when ALARM_SNOOZE_EN is defined; otherwise snooze is checked to be inert.
module tb_alarm_sound_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        one_second;
    logic        alarm_enable;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        stop_button;
    logic        snooze_button;
    logic        sound_alarm;
    logic        beep;
    logic        snoozing;
    logic [1:0]  snooze_count;

    int compared   = 0;
    int mismatched = 0;

    alarm_sound_controller dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .alarm_enable  (alarm_enable),
        .current_time  (current_time),
        .alarm_time    (alarm_time),
        .stop_button   (stop_button),
        .snooze_button (snooze_button),
        .sound_alarm   (sound_alarm),
        .beep          (beep),
        .snoozing      (snoozing),
        .snooze_count  (snooze_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input int seconds);
        for (int i = 0; i < seconds; i++) begin
            one_second = 1'b1;
            step();
            one_second = 1'b0;
            step();
        end
    endtask

    task automatic rearm();
        current_time = 16'h0731;
        step();
        current_time = 16'h0730;
        step();
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset         = 1'b1;
        one_second    = 1'b0;
        alarm_enable  = 1'b1;
        current_time  = 16'h0729;
        alarm_time    = 16'h0730;
        stop_button   = 1'b0;
        snooze_button = 1'b0;
        step();
        step();
        check_output("reset_sound", 16'(sound_alarm), 16'd0);
        check_output("reset_beep", 16'(beep), 16'd0);
        check_output("reset_snoozing", 16'(snoozing), 16'd0);
        check_output("reset_count", 16'(snooze_count), 16'd0);

        reset = 1'b0;
        step();
        check_output("idle_no_match", 16'(sound_alarm), 16'd0);

        current_time = 16'h0730;
        step();
        check_output("match_rings", 16'(sound_alarm), 16'd1);
        check_output("ring_beep_start", 16'(beep), 16'd0);

        apply_stimulus(1);
        check_output("beep_toggle_on", 16'(beep), 16'd1);
        apply_stimulus(1);
        check_output("beep_toggle_off", 16'(beep), 16'd0);
        apply_stimulus(57);
        check_output("ring_before_timeout", 16'(sound_alarm), 16'd1);
        check_output("beep_odd_second", 16'(beep), 16'd1);
        apply_stimulus(1);
        check_output("ring_timeout", 16'(sound_alarm), 16'd0);
        check_output("timeout_beep", 16'(beep), 16'd0);

        step();
        step();
        check_output("done_no_retrigger", 16'(sound_alarm), 16'd0);
        rearm();
        check_output("idle_retrigger", 16'(sound_alarm), 16'd1);

        stop_button = 1'b1;
        step();
        check_output("stop_silences", 16'(sound_alarm), 16'd0);
        step();
        stop_button = 1'b0;
        rearm();
        check_output("ring_after_stop", 16'(sound_alarm), 16'd1);

        stop_button   = 1'b1;
        snooze_button = 1'b1;
        step();
        check_output("both_sound", 16'(sound_alarm), 16'd0);
        check_output("both_snoozing", 16'(snoozing), 16'd0);
        stop_button   = 1'b0;
        snooze_button = 1'b0;
        step();
        rearm();
        check_output("ring_after_both", 16'(sound_alarm), 16'd1);

`ifdef ALARM_SNOOZE_EN
        for (int k = 1; k <= 3; k++) begin
            snooze_button = 1'b1;
            step();
            check_output("snooze_enter", 16'(snoozing), 16'd1);
            check_output("snooze_sound", 16'(sound_alarm), 16'd0);
            check_output("snooze_count", 16'(snooze_count), 16'(k));
            step();
            check_output("snooze_held_once", 16'(snooze_count), 16'(k));
            snooze_button = 1'b0;
            apply_stimulus(299);
            check_output("snooze_still", 16'(snoozing), 16'd1);
            apply_stimulus(1);
            check_output("snooze_expire_ring", 16'(sound_alarm), 16'd1);
            check_output("snooze_expire_flag", 16'(snoozing), 16'd0);
            check_output("snooze_expire_beep", 16'(beep), 16'd0);
        end

        snooze_button = 1'b1;
        step();
        check_output("fourth_snooze_sound", 16'(sound_alarm), 16'd1);
        check_output("fourth_snooze_flag", 16'(snoozing), 16'd0);
        check_output("fourth_snooze_count", 16'(snooze_count), 16'd3);
        snooze_button = 1'b0;
        step();

        stop_button = 1'b1;
        step();
        stop_button = 1'b0;
        check_output("done_sound", 16'(sound_alarm), 16'd0);
        check_output("done_holds_count", 16'(snooze_count), 16'd3);
        current_time = 16'h0731;
        step();
        step();
        check_output("idle_clears_count", 16'(snooze_count), 16'd0);

        current_time = 16'h0730;
        step();
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
        check_output("snooze_before_disable", 16'(snoozing), 16'd1);
        alarm_enable = 1'b0;
        step();
        check_output("disable_snoozing", 16'(snoozing), 16'd0);
        check_output("disable_sound", 16'(sound_alarm), 16'd0);
        check_output("disable_beep", 16'(beep), 16'd0);
        step();
        check_output("disable_count", 16'(snooze_count), 16'd0);
        alarm_enable = 1'b1;
        step();
        check_output("reenable_rings", 16'(sound_alarm), 16'd1);
`else
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
        check_output("nosnooze_sound", 16'(sound_alarm), 16'd1);
        check_output("nosnooze_flag", 16'(snoozing), 16'd0);
        check_output("nosnooze_count", 16'(snooze_count), 16'd0);
        alarm_enable = 1'b0;
        step();
        check_output("disable_sound", 16'(sound_alarm), 16'd0);
        alarm_enable = 1'b1;
        step();
        check_output("reenable_rings", 16'(sound_alarm), 16'd1);
`endif

        apply_stimulus(1);
        check_output("pre_reset_beep", 16'(beep), 16'd1);
        reset = 1'b1;
        #1;
        check_output("async_reset_sound", 16'(sound_alarm), 16'd0);
        check_output("async_reset_beep", 16'(beep), 16'd0);
        check_output("async_reset_snoozing", 16'(snoozing), 16'd0);
        step();
        reset = 1'b0;
        step();
        check_output("post_reset_rings", 16'(sound_alarm), 16'd1);
        check_output("post_reset_beep", 16'(beep), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
